m68k_region_decoder: RTL
========================

Name: m68k_region_decoder

Overview:
- Parametrised, table-driven successor to the fixed per-PCB M68K chip-select decode.
- Holds NUM_REGIONS runtime-loadable address windows with per-region wait states.
- Registers a one-hot chip select and generates DTACK_n, with bus-error timeout on unmapped accesses.
- Sits between the 68000 bus and the board peripherals; its config table is loaded from the per-PCB setup logic after reset.

Parameters:
- NUM_REGIONS, 24, number of decode windows / cs bits.
- IDX_W, 5, width of region index (>= clog2(NUM_REGIONS)).
- WAIT_W, 4, width of per-region wait-state count.
- TIMEOUT, 64, cycles before berr_n is asserted on an unmapped access (>= 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  write strobe for region table entry
- cfg_idx  in  IDX_W  entry to write; values >= NUM_REGIONS are ignored
- cfg_base  in  24  window base address
- cfg_width  in  5  low address bits ignored in the compare; values > 24 are treated as 24
- cfg_wait  in  WAIT_W  wait states inserted before DTACK
- cfg_en  in  1  entry enable
- cpu_a  in  24  68000 byte address
- cpu_as_n  in  1  address strobe, active low
- cs  out  NUM_REGIONS  registered one-hot chip select
- region_idx  out  IDX_W  index of the active region
- hit  out  1  a region is selected
- dtack_n  out  1  data acknowledge, active low
- berr_n  out  1  bus error, active low
- busy  out  1  state != IDLE

Behaviour:
- Reset (clk edge with reset=1):
  - All table entries: en=0, base=0, width=0, wait=0.
  - Outputs: cs=0, region_idx=0, hit=0, dtack_n=1, berr_n=1, busy=0, state=IDLE.
  - Reset mid-cycle aborts any access; the next cycle shows the reset values.
- Table writes:
  - cfg_we samples on the clk edge and writes all four fields of entry cfg_idx.
  - A write is allowed in any state. DECODE uses the table contents from before that edge's write.
- Match rule: entry i matches when en_i=1 and (cpu_a >> width_i) == (base_i >> width_i). Width 24 matches every address.
- Priority: the lowest matching index wins; cs is always one-hot or zero.
- States: IDLE, DECODE, WAIT, ACK, TOUT, BERR. Timing is counted from cycle N, the first edge where cpu_as_n=0 is sampled in IDLE.
- IDLE: on cpu_as_n=0, latch cpu_a and go to DECODE (state at N+1).
- DECODE (one cycle):
  - On a hit: register cs, region_idx and hit=1 (valid at N+2); load cnt=wait_i; go to WAIT.
  - On a miss: load cnt=TIMEOUT-1; go to TOUT. cs stays 0 and hit stays 0.
- WAIT:
  - cnt=0 → ACK, else cnt-1.
  - dtack_n goes low at N+3+wait.
- ACK: dtack_n=0; cs, region_idx and hit are held.
- TOUT:
  - cnt=0 → BERR, else cnt-1.
  - berr_n goes low at N+2+TIMEOUT.
- BERR: berr_n=0.
- Strobe release: in DECODE, WAIT, ACK, TOUT or BERR, a sample of cpu_as_n=1 returns to IDLE. On that same edge cs=0, hit=0, dtack_n=1 and berr_n=1; region_idx keeps its last value.
- Back-to-back accesses: IDLE needs at least one cycle with cpu_as_n=1 before a new access is latched. A strobe held low across accesses never re-triggers.
- Latched address: cpu_a changes after latch are ignored until the next IDLE.
- Counter width: cnt is max(WAIT_W, clog2(TIMEOUT)) bits.

Test Plan:
- Wait-state access:
  - Load entry 0: base 0x000000, width 19, wait 0, en. Load entry 3: base 0x080000, width 15, wait 2, en.
  - Access 0x081234 → cs=0b1000 and region_idx=3 at N+2; dtack_n low at N+5; all outputs release one cycle after cpu_as_n=1.
- Overlap priority: entries 1 and 2 both cover 0x400000 (widths 12 and 1) → cs=0b0010 only; dtack timing follows entry 1's wait.
- Unmapped access: 0xF00000 with TIMEOUT=64 → hit stays 0; berr_n low at N+66; berr_n returns high one cycle after the strobe releases.
- Aborted access: wait=10 with cpu_as_n released at N+6 → dtack_n is never asserted; busy=0 at the next edge; a new access after one high cycle decodes normally.
- Reconfiguration during an access:
  - Write entry 3 with en=0 at the DECODE edge → the in-flight access still hits region 3.
  - The next access to 0x081234 times out to berr.
- Reset during wait: reset asserted at N+3 → the next cycle shows all outputs at reset values, the table is cleared, and every access then bus-errors.

Source files
------------

// File: rtl/m68k_region_decoder.sv
// Table-driven 68000 chip-select decoder with per-region wait states,
// registered one-hot select, DTACK generation and unmapped bus-error timeout.
module m68k_region_decoder #(
  parameter int NUM_REGIONS = 24,
  parameter int IDX_W       = 5,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [23:0]            cfg_base,
  input  logic [4:0]             cfg_width,
  input  logic [WAIT_W-1:0]      cfg_wait,
  input  logic                   cfg_en,
  input  logic [23:0]            cpu_a,
  input  logic                   cpu_as_n,
  output logic [NUM_REGIONS-1:0] cs,
  output logic [IDX_W-1:0]       region_idx,
  output logic                   hit,
  output logic                   dtack_n,
  output logic                   berr_n,
  output logic                   busy
);

  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int CNT_W = (WAIT_W > TO_W) ? WAIT_W : TO_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK,
    S_TOUT,
    S_BERR
  } state_e;

  logic              en_q    [NUM_REGIONS];
  logic [23:0]       base_q  [NUM_REGIONS];
  logic [4:0]        width_q [NUM_REGIONS];
  logic [WAIT_W-1:0] wait_q  [NUM_REGIONS];

  state_e                 state_q;
  logic [23:0]            addr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   as_prev_q;
  logic [NUM_REGIONS-1:0] cs_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   hit_q;
  logic                   dtack_q;
  logic                   berr_q;

  logic              m_hit;
  logic [IDX_W-1:0]  m_idx;
  logic [WAIT_W-1:0] m_wait;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        en_q[i]    <= 1'b0;
        base_q[i]  <= '0;
        width_q[i] <= '0;
        wait_q[i]  <= '0;
      end
    end else if (cfg_we && (int'(cfg_idx) < NUM_REGIONS)) begin
      en_q[cfg_idx]    <= cfg_en;
      base_q[cfg_idx]  <= cfg_base;
      width_q[cfg_idx] <= (cfg_width > 5'd24) ? 5'd24 : cfg_width;
      wait_q[cfg_idx]  <= cfg_wait;
    end
  end

  // Scan high to low so the lowest matching index is the one kept.
  always_comb begin
    m_hit  = 1'b0;
    m_idx  = '0;
    m_wait = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (en_q[i] &&
          ((addr_q >> width_q[i]) == (base_q[i] >> width_q[i]))) begin
        m_hit  = 1'b1;
        m_idx  = IDX_W'(i);
        m_wait = wait_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      as_prev_q <= 1'b0;
      cs_q      <= '0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      dtack_q   <= 1'b1;
      berr_q    <= 1'b1;
    end else begin
      as_prev_q <= cpu_as_n;
      if (state_q != S_IDLE && cpu_as_n) begin
        state_q <= S_IDLE;
        cs_q    <= '0;
        hit_q   <= 1'b0;
        dtack_q <= 1'b1;
        berr_q  <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (!cpu_as_n && as_prev_q) begin
              addr_q  <= cpu_a;
              state_q <= S_DECODE;
            end
          end
          S_DECODE: begin
            if (m_hit) begin
              cs_q    <= NUM_REGIONS'(1) << m_idx;
              idx_q   <= m_idx;
              hit_q   <= 1'b1;
              cnt_q   <= CNT_W'(m_wait);
              state_q <= S_WAIT;
            end else begin
              cnt_q   <= CNT_W'(TIMEOUT - 1);
              state_q <= S_TOUT;
            end
          end
          S_WAIT: begin
            if (cnt_q == '0) begin
              dtack_q <= 1'b0;
              state_q <= S_ACK;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_TOUT: begin
            if (cnt_q == '0) begin
              berr_q  <= 1'b0;
              state_q <= S_BERR;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          S_ACK, S_BERR: begin
            state_q <= state_q;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cs         = cs_q;
  assign region_idx = idx_q;
  assign hit        = hit_q;
  assign dtack_n    = dtack_q;
  assign berr_n     = berr_q;
  assign busy       = (state_q != S_IDLE);

endmodule
